// File: rtl/lsu_dmem_if_if.sv
// Bundle of pipeline request/response and data-memory signals for lsu_dmem_if.
// slave is the LSU view; master is the pipeline/memory-side view.
interface lsu_dmem_if_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/lsu_dmem_if.sv
// Load/store unit front end: accepts one request, performs a single memory access
// cycle with byte-lane enables, and returns an extended load word or an error flag.
module lsu_dmem_if #(
    parameter int unsigned MEM_BYTES = 131072
) (
    input  logic          clk,
    input  logic          rstd,
    lsu_dmem_if_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic        store_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        err_q;

    logic        req_err;
    logic [3:0]  we_mask;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_data;

    always_comb begin
        req_err = 1'b0;
        we_mask = '0;
        case (bus.req_size)
            2'd0: we_mask = 4'b0001 << bus.req_addr[1:0];
            2'd1: begin
                req_err = bus.req_addr[0];
                we_mask = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: begin
                req_err = |bus.req_addr[1:0];
                we_mask = 4'b1111;
            end
            default: req_err = 1'b1;
        endcase
        if (bus.req_addr >= MEM_BYTES) req_err = 1'b1;
    end

    // Lane selection uses the latched address, which mem_addr holds during ACCESS.
    always_comb begin
        ld_b    = bus.mem_rdata[{bus.mem_addr[1:0], 3'b000} +: 8];
        ld_h    = bus.mem_rdata[{bus.mem_addr[1], 4'b0000} +: 16];
        ld_data = bus.mem_rdata;
        case (size_q)
            2'd0:    ld_data = uns_q ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
            2'd1:    ld_data = uns_q ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
            default: ld_data = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state         <= IDLE;
            store_q       <= 1'b0;
            size_q        <= '0;
            uns_q         <= 1'b0;
            err_q         <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_data  <= '0;
            bus.mem_we    <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        state         <= ACCESS;
                        store_q       <= bus.req_store;
                        size_q        <= bus.req_size;
                        uns_q         <= bus.req_unsigned;
                        err_q         <= req_err;
                        bus.req_ready <= 1'b0;
                        bus.mem_addr  <= bus.req_addr;
                        bus.mem_wdata <= bus.req_wdata;
                        bus.mem_we    <= (bus.req_store && !req_err) ? we_mask : 4'b0000;
                    end
                end
                ACCESS: begin
                    state         <= RESP;
                    bus.mem_we    <= '0;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= err_q;
                    bus.rsp_data  <= (store_q || err_q) ? 32'h0 : ld_data;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_dmem_if.md
LSU_DMEM_IF -- requirements
Module: lsu_dmem_if

Interface
REQ-001 Parameter MEM_BYTES, default 131072, size in bytes of the downstream data memory; addresses at or above it are out of range.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstd  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  pipeline presents a load/store request.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_store  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
REQ-008 req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  pipeline consumes the response.
REQ-013 rsp_data  output  32  extended load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  access was misaligned, out of range or illegal size.
REQ-015 mem_addr  output  32  byte address to data memory.
REQ-016 mem_we  output  4  byte-lane write enables to data memory.
REQ-017 mem_wdata  output  32  write data to data memory.
REQ-018 mem_rdata  input  32  combinational read word from data memory at mem_addr.

Function
REQ-019 FSM states: IDLE, ACCESS, RESP; IDLE->ACCESS on req_valid&&req_ready; ACCESS->RESP unconditionally; RESP->IDLE on rsp_ready, else hold.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted in that cycle and all request fields are latched.
REQ-021 Error SHALL be flagged when size==3, half with addr[0]!=0, word with addr[1:0]!=0, or addr>=MEM_BYTES; lane-straddling half (offset 1) is an error.
REQ-022 mem_addr SHALL drive the latched address in every state; mem_wdata SHALL drive latched req_wdata unshifted, since the memory packs low bytes into enabled lanes in ascending order.
REQ-023 mem_we SHALL be nonzero only in ACCESS for a store without error: byte at offset k -> 1<<k; half offset 0 -> 0011, offset 2 -> 1100; word -> 1111.
REQ-024 Loads SHALL sample mem_rdata at the end of ACCESS: byte = rdata[8k+:8], half = rdata[16*addr[1]+:16], word = rdata, extended per req_unsigned.
REQ-025 rsp_valid SHALL be 1 exactly in RESP; rsp_data/rsp_err SHALL be stable while rsp_valid && !rsp_ready.
REQ-026 Erroneous requests SHALL still traverse ACCESS and RESP (3-cycle minimum) with no memory write and rsp_data=0.
REQ-027 Request fields changing while not accepted SHALL have no effect; latency accept-to-rsp_valid is exactly 2 cycles.

Reset
REQ-028 rstd low SHALL immediately force IDLE, req_ready=1 (once rstd high), rsp_valid=0, rsp_err=0, rsp_data=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-029 Reset asserted during ACCESS SHALL drop mem_we to 0 before the next clock edge; the in-flight request is discarded.

Verification
REQ-030 SB addr 0x103, wdata 0xAABBCCDD -> ACCESS cycle mem_we=1000, mem_addr=0x103, mem_wdata=0xAABBCCDD; rsp_err=0, rsp_data=0.
REQ-031 LB signed addr 0x102, mem_rdata 0x12F45678 -> rsp_data=0xFFFFFFF4; LBU -> 0x000000F4; LHU addr 0x102 -> 0x000012F4.
REQ-032 LW addr 0x101 -> rsp_err=1, rsp_data=0, mem_we stays 0; SW addr 0x20000 (MEM_BYTES) -> rsp_err=1, no write.
REQ-033 Load with rsp_ready held 0 for 3 cycles -> rsp_valid held 4 cycles, rsp_data constant, req_ready=0 throughout.
REQ-034 Back-to-back SW 0x10 then LW 0x10 with memory model -> load returns the stored word.
REQ-035 rstd pulsed low during store ACCESS -> mem_we=0 asynchronously, rsp_valid never asserts, state IDLE after release.
